pci_debug_trace_responder: RTL and testbench

Per-tile debug trace buffer and read responder for the PCI debug path. It captures a stream of trace words into a circular buffer. It serves burst reads issued by the PCI arbiter over the debug bus (`arvalid`/`arlen` in, `rdata`/`rvalid`/`rlast` out), returning one header line and then the oldest captured entries. One instance sits in each tile, and one sits at the top level as the self-debug target.

---
 rtl/pci_debug_trace_responder.sv | 140 ++++++++++++++
 tb/tb_pci_debug_trace_responder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_debug_trace_responder.sv
// Per-tile debug trace buffer: captures trace words into a circular RAM and
// answers debug-bus burst reads with a header beat followed by the oldest entries.
module pci_debug_trace_responder #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned LOG_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wvalid,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 arvalid,
  input  logic [7:0]           arlen,
  input  logic                 rready,
  output logic [511:0]         rdata,
  output logic                 rvalid,
  output logic                 rlast,
  output logic [LOG_DEPTH:0]   size,
  output logic [15:0]          drops
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned RW    = 512;
  localparam int unsigned SW    = LOG_DEPTH + 1;
  localparam int unsigned PADW  = RW - 40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_DATA
  } state_t;

  logic [WIDTH-1:0]     mem [DEPTH];

  state_t               state_q;
  logic [LOG_DEPTH-1:0] head_q, head_d;
  logic [LOG_DEPTH-1:0] tail_q, tail_d;
  logic [SW-1:0]        size_q, size_d;
  logic [15:0]          drops_q, drops_d;
  logic [8:0]           beats_q;
  logic                 nonempty_q;
  logic [RW-1:0]        rdata_q;
  logic                 rvalid_q;
  logic                 rlast_q;

  logic                 pop, push, drop, full, hdr_ack;

  // Capture/pop bookkeeping; a pop in the same cycle frees the slot for a capture.
  always_comb begin
    pop     = (state_q == S_DATA) && rready && nonempty_q;
    hdr_ack = (state_q == S_HEADER) && rready;
    full    = (size_q == SW'(DEPTH));
    push    = wvalid && (!full || pop);
    drop    = wvalid && !push;

    size_d = size_q;
    if (push && !pop) begin
      size_d = size_q + SW'(1);
    end else if (pop && !push) begin
      size_d = size_q - SW'(1);
    end

    head_d = pop  ? head_q + LOG_DEPTH'(1) : head_q;
    tail_d = push ? tail_q + LOG_DEPTH'(1) : tail_q;

    drops_d = drops_q;
    if (hdr_ack) begin
      drops_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  // Trace storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_q] <= wdata;
    end
  end

  // Burst FSM with registered read-channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      size_q     <= '0;
      drops_q    <= '0;
      beats_q    <= '0;
      nonempty_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      size_q  <= size_d;
      drops_q <= drops_d;
      case (state_q)
        S_IDLE: begin
          if (arvalid) begin
            beats_q  <= 9'(arlen) + 9'd1;
            rdata_q  <= {{PADW{1'b0}}, 8'(LOG_DEPTH), drops_q, 16'(size_q)};
            rvalid_q <= 1'b1;
            rlast_q  <= (arlen == 8'd0);
            state_q  <= S_HEADER;
          end
        end
        S_HEADER, S_DATA: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (beats_q == 9'd1) begin
              state_q <= S_IDLE;
            end else begin
              beats_q <= beats_q - 9'd1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // rdata_q doubles as the synchronous RAM read register.
          nonempty_q <= (size_q != '0);
          rdata_q    <= (size_q != '0) ? RW'(mem[head_q]) : '0;
          rvalid_q   <= 1'b1;
          rlast_q    <= (beats_q == 9'd1);
          state_q    <= S_DATA;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign size   = size_q;
  assign drops  = drops_q;

endmodule

// File: tb/tb_pci_debug_trace_responder.sv
// Directed bench for pci_debug_trace_responder: a depth-16 instance for the
// scenarios plus a default-parameter instance sharing the same stimulus.
module tb_pci_debug_trace_responder;

  logic         clk = 1'b0;
  logic         rst, wvalid, arvalid, rready;
  logic [31:0]  wdata;
  logic [7:0]   arlen;
  logic [511:0] rdata;
  logic         rvalid, rlast;
  logic [4:0]   size;
  logic [15:0]  drops;

  logic [511:0] wdata10;
  logic [511:0] rdata10;
  logic         rvalid10, rlast10;
  logic [10:0]  size10;
  logic [15:0]  drops10;

  int tests = 0;
  int fails = 0;

  assign wdata10 = 512'(wdata);

  always #5 clk = ~clk;

  pci_debug_trace_responder #(.WIDTH(32), .LOG_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .wvalid(wvalid), .wdata(wdata), .arvalid(arvalid),
    .arlen(arlen), .rready(rready), .rdata(rdata), .rvalid(rvalid),
    .rlast(rlast), .size(size), .drops(drops)
  );

  pci_debug_trace_responder u_dut10 (
    .clk(clk), .rst(rst), .wvalid(wvalid), .wdata(wdata10), .arvalid(arvalid),
    .arlen(arlen), .rready(rready), .rdata(rdata10), .rvalid(rvalid10),
    .rlast(rlast10), .size(size10), .drops(drops10)
  );

  function automatic logic [511:0] hdr(input int s, input int dr, input int ld);
    return {472'd0, 8'(ld), 16'(dr), 16'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wvalid = 1'b1;
    wdata  = d;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic issue_read(input logic [7:0] len);
    arvalid = 1'b1;
    arlen   = len;
    tick();
    arvalid = 1'b0;
  endtask

  // Waits (bounded) for a beat with rready high and accepts it.
  task automatic get_beat(output logic [511:0] d, output logic l, output bit ok);
    rready = 1'b1;
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid) begin
        d  = rdata;
        l  = rlast;
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 || size !== 5'd0 || drops !== 16'd0 || size10 !== 11'd0) begin
      fails++;
      $display("FAIL reset: rvalid=%b rlast=%b rdata=%h size=%0d drops=%0d size10=%0d, want all zero",
               rvalid, rlast, rdata, size, drops, size10);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [511:0] d;
    logic l;
    bit ok;
    logic [31:0] ent [3];
    ent[0] = 32'hA0A0_0001;
    ent[1] = 32'hB0B0_0002;
    ent[2] = 32'hC0C0_0003;
    do_reset();
    for (int k = 0; k < 3; k++) push(ent[k]);
    tests++;
    if (size !== 5'd3 || size10 !== 11'd3) begin
      fails++;
      $display("FAIL basic_size: size=%0d size10=%0d, want 3", size, size10);
    end
    issue_read(8'd3);
    tests++;
    if (rvalid10 !== 1'b1 || rlast10 !== 1'b0 || drops10 !== 16'd0 || rdata10 !== hdr(3, 0, 10)) begin
      fails++;
      $display("FAIL basic_hdr_default: rvalid=%b rlast=%b drops=%0d rdata=%h, want %h",
               rvalid10, rlast10, drops10, rdata10, hdr(3, 0, 10));
    end
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(3, 0, 4) || l !== 1'b0) begin
      fails++;
      $display("FAIL basic_hdr: ok=%b rlast=%b rdata=%h, want %h rlast=0", ok, l, d, hdr(3, 0, 4));
    end
    for (int k = 0; k < 3; k++) begin
      get_beat(d, l, ok);
      tests++;
      if (!ok || d !== 512'(ent[k]) || l !== (k == 2)) begin
        fails++;
        $display("FAIL basic_beat%0d: ok=%b rlast=%b rdata=%h, want %h", k, ok, l, d, ent[k]);
      end
    end
    tests++;
    if (size !== 5'd0 || rvalid !== 1'b0) begin
      fails++;
      $display("FAIL basic_end: size=%0d rvalid=%b, want 0 0", size, rvalid);
    end
  endtask

  task automatic test_drops();
    logic [511:0] d;
    logic l;
    bit ok;
    do_reset();
    wvalid = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      wdata = 32'(i);
      tick();
    end
    wvalid = 1'b0;
    tests++;
    if (size !== 5'd16 || drops !== 16'd5) begin
      fails++;
      $display("FAIL drops_count: size=%0d drops=%0d, want 16 5", size, drops);
    end
    issue_read(8'd0);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(16, 5, 4) || l !== 1'b1) begin
      fails++;
      $display("FAIL drops_hdr: ok=%b rlast=%b rdata=%h, want %h rlast=1", ok, l, d, hdr(16, 5, 4));
    end
    tests++;
    if (drops !== 16'd0 || rvalid !== 1'b0 || size !== 5'd16) begin
      fails++;
      $display("FAIL drops_clear: drops=%0d rvalid=%b size=%0d, want 0 0 16", drops, rvalid, size);
    end
    // drop coinciding with header accept leaves drops at 1
    issue_read(8'd0);
    rready = 1'b1;
    wvalid = 1'b1;
    wdata  = 32'd99;
    tick();
    wvalid = 1'b0;
    tests++;
    if (drops !== 16'd1 || rvalid !== 1'b0 || size !== 5'd16) begin
      fails++;
      $display("FAIL drops_same_cycle: drops=%0d rvalid=%b size=%0d, want 1 0 16", drops, rvalid, size);
    end
    issue_read(8'd16);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(16, 1, 4) || l !== 1'b0) begin
      fails++;
      $display("FAIL drops_hdr2: ok=%b rdata=%h, want %h", ok, d, hdr(16, 1, 4));
    end
    for (int k = 0; k < 16; k++) begin
      get_beat(d, l, ok);
      tests++;
      if (!ok || d !== 512'(k) || l !== (k == 15)) begin
        fails++;
        $display("FAIL drops_beat%0d: ok=%b rlast=%b rdata=%h, want %0d", k, ok, l, d, k);
      end
    end
    tests++;
    if (size !== 5'd0) begin
      fails++;
      $display("FAIL drops_end: size=%0d, want 0", size);
    end
  endtask

  task automatic test_underflow();
    logic [511:0] d;
    logic l;
    bit ok;
    logic [31:0] exp [5];
    exp[0] = 32'h0;
    exp[1] = 32'h1111_2222;
    exp[2] = 32'h3333_4444;
    exp[3] = 32'h0;
    exp[4] = 32'h0;
    do_reset();
    push(exp[1]);
    push(exp[2]);
    issue_read(8'd4);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(2, 0, 4) || l !== 1'b0) begin
      fails++;
      $display("FAIL under_hdr: ok=%b rdata=%h, want %h", ok, d, hdr(2, 0, 4));
    end
    for (int k = 1; k < 5; k++) begin
      get_beat(d, l, ok);
      tests++;
      if (!ok || d !== 512'(exp[k]) || l !== (k == 4)) begin
        fails++;
        $display("FAIL under_beat%0d: ok=%b rlast=%b rdata=%h, want %h", k, ok, l, d, exp[k]);
      end
    end
    tests++;
    if (size !== 5'd0 || u_dut.head_q !== u_dut.tail_q) begin
      fails++;
      $display("FAIL under_end: size=%0d head=%0d tail=%0d, want 0 and head==tail",
               size, u_dut.head_q, u_dut.tail_q);
    end
  endtask

  task automatic test_full_concurrent();
    logic [511:0] d;
    logic l;
    bit ok;
    do_reset();
    wvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 32'(100 + i);
      tick();
    end
    wvalid = 1'b0;
    issue_read(8'd17);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(16, 0, 4)) begin
      fails++;
      $display("FAIL full_hdr: ok=%b rdata=%h, want %h", ok, d, hdr(16, 0, 4));
    end
    wait_valid(ok);
    tests++;
    if (!ok || rdata !== 512'(100)) begin
      fails++;
      $display("FAIL full_beat0: ok=%b rdata=%h, want 100", ok, rdata);
    end
    wvalid = 1'b1;
    wdata  = 32'h0000_BEEF;
    tick();
    wvalid = 1'b0;
    tests++;
    if (drops !== 16'd0 || size !== 5'd16) begin
      fails++;
      $display("FAIL full_concurrent: drops=%0d size=%0d, want 0 16", drops, size);
    end
    for (int k = 1; k < 17; k++) begin
      get_beat(d, l, ok);
      tests++;
      if (!ok || d !== ((k == 16) ? 512'(32'h0000_BEEF) : 512'(100 + k)) || l !== (k == 16)) begin
        fails++;
        $display("FAIL full_beat%0d: ok=%b rlast=%b rdata=%h", k, ok, l, d);
      end
    end
    tests++;
    if (size !== 5'd0) begin
      fails++;
      $display("FAIL full_end: size=%0d, want 0", size);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] d;
    logic l;
    bit ok;
    do_reset();
    push(32'h5A5A_0000);
    push(32'h5A5A_0001);
    issue_read(8'd1);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(2, 0, 4) || l !== 1'b0) begin
      fails++;
      $display("FAIL bp_hdr: ok=%b rdata=%h, want %h", ok, d, hdr(2, 0, 4));
    end
    rready = 1'b0;
    wait_valid(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_wait: rvalid never rose, want 1");
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        arvalid = 1'b1;
        arlen   = 8'd5;
      end
      tick();
      arvalid = 1'b0;
      tests++;
      if (rvalid !== 1'b1 || rlast !== 1'b1 || rdata !== 512'(32'h5A5A_0000) || size !== 5'd2) begin
        fails++;
        $display("FAIL bp_hold%0d: rvalid=%b rlast=%b rdata=%h size=%0d, want 1 1 5a5a0000 2",
                 c, rvalid, rlast, rdata, size);
      end
    end
    rready = 1'b1;
    tick();
    tests++;
    if (rvalid !== 1'b0 || size !== 5'd1) begin
      fails++;
      $display("FAIL bp_accept: rvalid=%b size=%0d, want 0 1", rvalid, size);
    end
    tick();
    tick();
    tick();
    tests++;
    if (rvalid !== 1'b0) begin
      fails++;
      $display("FAIL bp_ignored_ar: rvalid=%b, want 0", rvalid);
    end
    issue_read(8'd0);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(1, 0, 4) || l !== 1'b1) begin
      fails++;
      $display("FAIL bp_reread: ok=%b rdata=%h, want %h", ok, d, hdr(1, 0, 4));
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    logic l;
    bit ok;
    do_reset();
    wvalid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wdata = 32'(200 + i);
      tick();
    end
    wvalid = 1'b0;
    issue_read(8'd3);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(16, 2, 4)) begin
      fails++;
      $display("FAIL rstmid_hdr: ok=%b rdata=%h, want %h", ok, d, hdr(16, 2, 4));
    end
    wait_valid(ok);
    tests++;
    if (!ok || rdata !== 512'(200)) begin
      fails++;
      $display("FAIL rstmid_beat2: ok=%b rdata=%h, want 200", ok, rdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 || size !== 5'd0 || drops !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: rvalid=%b rlast=%b size=%0d drops=%0d, want all zero",
               rvalid, rlast, size, drops);
    end
    issue_read(8'd0);
    get_beat(d, l, ok);
    tests++;
    if (!ok || d !== hdr(0, 0, 4) || l !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_fresh: ok=%b rdata=%h, want %h", ok, d, hdr(0, 0, 4));
    end
  endtask

  initial begin
    rst     = 1'b1;
    wvalid  = 1'b0;
    wdata   = '0;
    arvalid = 1'b0;
    arlen   = '0;
    rready  = 1'b1;
    test_reset();
    test_basic();
    test_drops();
    test_underflow();
    test_full_concurrent();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
